mmu_dm_arbiter: RTL and testbench
=================================

Name: mmu_dm_arbiter

Overview:
Shares the single MMU data-memory port between two requesters: the CPU memory stage (port 0) and a DMA/debug loader (port 1).
- Arbitrates every cycle and drives the MMU dm_* inputs.
- Tracks which requester owns the one-cycle-latency response and routes dm_do back to it.
- Sits between the pipeline's MEM stage and the MMU.

Parameters:
MAX_WAIT, 4, consecutive denied DMA cycles before the DMA is force-granted over the CPU (1..2^WAIT_W-1)
WAIT_W, 3, width of the starvation counter
MAX_BURST, 8, maximum consecutive locked DMA grants (1..2^BURST_W-1)
BURST_W, 4, width of the burst counter
IDLE_ADDR, 32'h00000000, address driven to the MMU when nothing is granted (ROM region, so no IO side effects)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request
cpu_we  in  1  CPU write enable
cpu_addr  in  32  CPU byte address
cpu_di  in  32  CPU write data, right-aligned
cpu_be  in  4  CPU byte enable, non-encoded
cpu_signed  in  1  CPU sign-extend load
cpu_gnt  out  1  CPU request accepted this cycle (combinational)
cpu_rvalid  out  1  CPU response valid
cpu_do  out  32  CPU read data
dma_req, dma_we, dma_addr[31:0], dma_di[31:0], dma_be[3:0], dma_signed  in  —  same meanings, DMA side
dma_lock  in  1  DMA requests back-to-back burst ownership
dma_gnt  out  1  DMA request accepted this cycle (combinational)
dma_rvalid  out  1  DMA response valid
dma_do  out  32  DMA read data
dm_we  out  1  to MMU dm_we
dm_addr  out  32  to MMU dm_addr
dm_di  out  32  to MMU dm_di
dm_be  out  4  to MMU dm_be
is_signed  out  1  to MMU is_signed
dm_do  in  32  from MMU, valid one clock after the access

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- At most one of cpu_gnt/dma_gnt is high in any cycle. A grant means the MMU samples that requester's fields at this clk edge.
- Ungranted cycle:
  - dm_we=0, dm_addr=IDLE_ADDR, dm_be=4'b1111, is_signed=0, dm_di=0.
  - A DMA write never reaches the MMU without dma_gnt.
- State machine, 2 states:
  - ARB_NORMAL (reset state):
    - Only one requester asserts → grant it.
    - Both assert → grant CPU, unless wait_cnt==MAX_WAIT, then grant DMA.
  - ARB_NORMAL → ARB_BURST: at the edge where dma_gnt=1 and dma_lock=1; burst_cnt loads 1.
  - ARB_BURST:
    - dma_req&&dma_lock → grant DMA (CPU stalled); burst_cnt increments.
    - Leave to ARB_NORMAL when dma_req=0, dma_lock=0, or burst_cnt==MAX_BURST.
    - The exit cycle arbitrates as ARB_NORMAL (no dead cycle). On burst_cnt==MAX_BURST, the CPU wins that cycle if requesting.
- wait_cnt (WAIT_W bits):
  - Increments when dma_req=1 and dma_gnt=0.
  - Clears when dma_gnt=1 or dma_req=0.
  - Saturates at MAX_WAIT.
- Response routing:
  - owner_p[1:0] is registered each edge: {dma_gnt,cpu_gnt}.
  - Next cycle: cpu_rvalid=owner_p[0], dma_rvalid=owner_p[1].
  - The owning port's *_do is dm_do; the non-owning *_do is 0.
- Latency: request to rvalid = 1 clock, for both reads and writes (write rvalid is an acknowledge; its data is don't-care).
- Throughput: one access per cycle, fully pipelined. A response and a new grant may coincide.
- Reset:
  - State → ARB_NORMAL; wait_cnt, burst_cnt, owner_p → 0.
  - All gnt/rvalid outputs are 0 during reset and in the first cycle after it. A response in flight at reset is dropped.
- Requester contract: a requester holds its fields stable while req=1 and gnt=0. The arbiter does not latch requests.

Decomposition:
- Shared package mmu_arb_pkg: state encoding ARB_NORMAL/ARB_BURST, and owner bit indices OWN_CPU=0, OWN_DMA=1.
- No sub-module; a single module of about 150 lines.

Test Plan:
- CPU-only: cpu_req read 0x10000010 be=1111 → cpu_gnt same cycle; dm_addr=0x10000010; next cycle cpu_rvalid=1, cpu_do=dm_do, dma_rvalid=0.
- Contention with MAX_WAIT=4: both req held continuously → CPU granted cycles 0-3, DMA granted cycle 4, wait_cnt=0 after, CPU resumes cycle 5.
- Locked burst with MAX_BURST=8: dma_req+dma_lock held, cpu_req held → 8 consecutive dma_gnt; cycle 9 cpu_gnt=1; dma_rvalid pulses 8 times, each one cycle after its grant.
- Idle safety: no requests, DMA write pending but denied → dm_we=0, dm_addr=0x00000000 in every ungranted cycle; no write reaches 0x80000000 IO.
- Back-to-back alternation: CPU write 0x10000000 then DMA read 0x10000000 → cpu_rvalid then dma_rvalid on consecutive cycles; dma_do equals the written word.
- Reset mid-access: assert reset in the cycle after a DMA grant → dma_rvalid=0 that cycle and the next; state ARB_NORMAL; first post-reset request is granted normally.

Source files
------------

// File: rtl/mmu_arb_pkg.sv
// Shared definitions for the MMU data-memory port arbiter.
package mmu_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Bit positions inside the registered response-owner vector.
  localparam int unsigned OWN_CPU = 0;
  localparam int unsigned OWN_DMA = 1;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_BURST  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mmu_dm_arbiter.sv
// Shares the single MMU data-memory port between the CPU MEM stage and a DMA/debug loader,
// with DMA starvation protection, locked DMA bursts and one-cycle response routing.
module mmu_dm_arbiter
  import mmu_arb_pkg::*;
#(
  parameter int unsigned       MAX_WAIT  = 4,
  parameter int unsigned       WAIT_W    = 3,
  parameter int unsigned       MAX_BURST = 8,
  parameter int unsigned       BURST_W   = 4,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_di,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic              cpu_signed,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_do,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_di,
  input  logic [BE_W-1:0]   dma_be,
  input  logic              dma_signed,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_do,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_di,
  output logic [BE_W-1:0]   dm_be,
  output logic              is_signed,
  input  logic [DATA_W-1:0] dm_do
);

  arb_state_e         state, state_next;
  logic [WAIT_W-1:0]  wait_cnt, wait_next;
  logic [BURST_W-1:0] burst_cnt, burst_next;
  logic [1:0]         owner_p;
  logic               blocked_q;
  logic               grant_en;
  logic               starved;
  logic               normal_dma;
  logic               hold_burst;

  // No grants while in reset nor in the first cycle after it.
  assign grant_en = !(reset || blocked_q);
  assign starved  = (wait_cnt == WAIT_W'(MAX_WAIT));

  // Arbitration, burst tracking and starvation counter.
  always_comb begin
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    state_next = ARB_NORMAL;
    burst_next = '0;
    wait_next  = wait_cnt;
    normal_dma = dma_req && (!cpu_req || starved);
    hold_burst = (state == ARB_BURST) && dma_req && dma_lock &&
                 (burst_cnt != BURST_W'(MAX_BURST));

    if (grant_en) begin
      if (hold_burst) begin
        dma_gnt = 1'b1;
      end else begin
        dma_gnt = normal_dma;
        cpu_gnt = cpu_req && !normal_dma;
      end
    end

    // A burst exit cycle arbitrates normally and may immediately start a new burst.
    if (dma_gnt && dma_lock) begin
      state_next = ARB_BURST;
      burst_next = hold_burst ? burst_cnt + BURST_W'(1) : BURST_W'(1);
    end

    if (!dma_req || dma_gnt) begin
      wait_next = '0;
    end else if (!starved) begin
      wait_next = wait_cnt + WAIT_W'(1);
    end
  end

  // Drive the MMU from the granted requester, or a side-effect-free idle access.
  always_comb begin
    dm_we     = 1'b0;
    dm_addr   = IDLE_ADDR;
    dm_di     = '0;
    dm_be     = '1;
    is_signed = 1'b0;
    if (cpu_gnt) begin
      dm_we     = cpu_we;
      dm_addr   = cpu_addr;
      dm_di     = cpu_di;
      dm_be     = cpu_be;
      is_signed = cpu_signed;
    end else if (dma_gnt) begin
      dm_we     = dma_we;
      dm_addr   = dma_addr;
      dm_di     = dma_di;
      dm_be     = dma_be;
      is_signed = dma_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_NORMAL;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      owner_p   <= '0;
      blocked_q <= 1'b1;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_next;
      burst_cnt <= burst_next;
      owner_p   <= {dma_gnt, cpu_gnt};
      blocked_q <= 1'b0;
    end
  end

  // A response in flight when reset arrives is dropped.
  assign cpu_rvalid = owner_p[OWN_CPU] && !reset;
  assign dma_rvalid = owner_p[OWN_DMA] && !reset;
  assign cpu_do     = cpu_rvalid ? dm_do : '0;
  assign dma_do     = dma_rvalid ? dm_do : '0;

endmodule

// File: tb/tb_mmu_dm_arbiter.sv
// Scoreboard bench for mmu_dm_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares them; a small MMU model answers one clock later.
module tb_mmu_dm_arbiter;

  typedef struct packed {
    logic        port;   // 0 = CPU, 1 = DMA
    logic        rd;     // data compared only for reads
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_signed, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_di, cpu_do;
  logic [3:0]  cpu_be;
  logic        dma_req, dma_we, dma_signed, dma_lock, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_di, dma_do;
  logic [3:0]  dma_be;
  logic        dm_we, is_signed;
  logic [31:0] dm_addr, dm_di, dm_do;
  logic [3:0]  dm_be;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic drop_next = 1'b0;
  logic io_wr = 1'b0;
  logic [31:0] mem [logic [31:0]];

  mmu_dm_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_be(cpu_be), .cpu_signed(cpu_signed), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_do(cpu_do),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_di(dma_di),
    .dma_be(dma_be), .dma_signed(dma_signed), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_do(dma_do),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di), .dm_be(dm_be),
    .is_signed(is_signed), .dm_do(dm_do)
  );

  always #5 clk = ~clk;

  // MMU model: returns the pre-write word one clock after the access.
  always @(posedge clk) begin
    dm_do <= mem.exists(dm_addr) ? mem[dm_addr] : (dm_addr ^ 32'h5A5A_5A5A);
    if (dm_we === 1'b1) begin
      mem[dm_addr] = dm_di;
      if (dm_addr[31]) io_wr = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic clr();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_di = '0; cpu_be = 4'hF; cpu_signed = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_di = '0; dma_be = 4'hF; dma_signed = 1'b0;
    dma_lock = 1'b0;
  endtask

  // One arbitration cycle: check grants and the MMU bus, queue the expected response.
  task automatic step(input logic ecg, input logic edg, input logic [31:0] edata);
    exp_t e;
    @(negedge clk);
    chk("cpu_gnt", 32'(cpu_gnt), 32'(ecg));
    chk("dma_gnt", 32'(dma_gnt), 32'(edg));
    if (ecg) begin
      chk("dm_addr_cpu", dm_addr, cpu_addr);
      chk("dm_we_cpu", 32'(dm_we), 32'(cpu_we));
      chk("dm_di_cpu", dm_di, cpu_di);
      chk("dm_be_cpu", 32'(dm_be), 32'(cpu_be));
      chk("is_signed_cpu", 32'(is_signed), 32'(cpu_signed));
      e = '{port: 1'b0, rd: !cpu_we, data: edata};
      if (!drop_next) exp_q.push_back(e);
    end else if (edg) begin
      chk("dm_addr_dma", dm_addr, dma_addr);
      chk("dm_we_dma", 32'(dm_we), 32'(dma_we));
      chk("dm_di_dma", dm_di, dma_di);
      chk("dm_be_dma", 32'(dm_be), 32'(dma_be));
      e = '{port: 1'b1, rd: !dma_we, data: edata};
      if (!drop_next) exp_q.push_back(e);
    end else begin
      chk("idle_we", 32'(dm_we), 32'h0);
      chk("idle_addr", dm_addr, 32'h0000_0000);
      chk("idle_be", 32'(dm_be), 32'hF);
      chk("idle_di", dm_di, 32'h0);
      chk("idle_signed", 32'(is_signed), 32'h0);
    end
    @(posedge clk); #1;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (cpu_rvalid || dma_rvalid) begin
        chk("rvalid_onehot", 32'(cpu_rvalid && dma_rvalid), 32'h0);
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 32'(dma_rvalid), 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rvalid_port", 32'(dma_rvalid), 32'(mon_e.port));
          if (mon_e.port) begin
            if (mon_e.rd) chk("dma_do", dma_do, mon_e.data);
            chk("cpu_do_idle", cpu_do, 32'h0);
          end else begin
            if (mon_e.rd) chk("cpu_do", cpu_do, mon_e.data);
            chk("dma_do_idle", dma_do, 32'h0);
          end
        end
      end else begin
        chk("no_rvalid_do", cpu_do | dma_do, 32'h0);
      end
    end
  end

  initial begin
    clr();
    reset = 1'b1;
    // Requests present during reset, including a DMA write to the IO region.
    cpu_req = 1'b1; cpu_addr = 32'h1000_0010;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h8000_0000; dma_di = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
    chk("rst_dma_gnt", 32'(dma_gnt), 32'h0);
    chk("rst_rvalid", 32'(cpu_rvalid | dma_rvalid), 32'h0);
    chk("rst_dm_we", 32'(dm_we), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 32'h0);                     // first cycle after reset: no grants

    // CPU-only reads.
    dma_req = 1'b0;
    step(1'b1, 1'b0, 32'h4A5A_5A4A);
    cpu_addr = 32'h1000_0022; cpu_be = 4'b0011; cpu_signed = 1'b1;
    step(1'b1, 1'b0, 32'h4A5A_5A78);
    cpu_req = 1'b0;
    step(1'b0, 1'b0, 32'h0);                     // denied IO write fields stay off the bus

    // Contention: starvation counter forces the DMA in on the fifth cycle.
    clr();
    cpu_req = 1'b1; cpu_addr = 32'h1000_0100;
    dma_req = 1'b1; dma_addr = 32'h2000_0000;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h4A5A_5B5A);
    step(1'b0, 1'b1, 32'h7A5A_5A5A);
    step(1'b1, 1'b0, 32'h4A5A_5B5A);
    clr();
    step(1'b0, 1'b0, 32'h0);

    // Locked burst capped at eight grants, then the CPU wins.
    dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'h2000_0040;
    step(1'b0, 1'b1, rd_val(32'h2000_0040));
    cpu_req = 1'b1; cpu_addr = 32'h1000_0200;
    for (int i = 1; i < 8; i++) begin
      dma_addr = 32'h2000_0040 + 32'(4 * i);
      step(1'b0, 1'b1, rd_val(dma_addr));
    end
    step(1'b1, 1'b0, rd_val(32'h1000_0200));
    clr();
    step(1'b0, 1'b0, 32'h0);

    // Burst ended early by dropping dma_lock.
    dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'h2000_0080;
    step(1'b0, 1'b1, rd_val(32'h2000_0080));
    cpu_req = 1'b1; cpu_addr = 32'h1000_0300;
    step(1'b0, 1'b1, rd_val(32'h2000_0080));
    dma_lock = 1'b0;
    step(1'b1, 1'b0, rd_val(32'h1000_0300));
    clr();
    step(1'b0, 1'b0, 32'h0);

    // CPU write then DMA read of the same word on consecutive cycles.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1000_0000; cpu_di = 32'hCAFE_F00D;
    step(1'b1, 1'b0, 32'h0);
    clr();
    dma_req = 1'b1; dma_addr = 32'h1000_0000;
    step(1'b0, 1'b1, 32'hCAFE_F00D);
    clr();
    step(1'b0, 1'b0, 32'h0);

    // Reset right after a locked DMA grant drops its response and clears the burst.
    dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'h2000_0100;
    drop_next = 1'b1;
    step(1'b0, 1'b1, 32'h0);
    drop_next = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h1000_0400;
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_dma_rvalid", 32'(dma_rvalid), 32'h0);
    chk("rstmid_gnt", 32'(cpu_gnt | dma_gnt), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstpost_dma_rvalid", 32'(dma_rvalid), 32'h0);
    chk("rstpost_gnt", 32'(cpu_gnt | dma_gnt), 32'h0);
    @(posedge clk); #1;
    step(1'b1, 1'b0, rd_val(32'h1000_0400));      // normal arbitration, not a held burst
    clr();
    step(1'b0, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_responses", 32'(exp_q.size()), 32'h0);
    chk("io_write_leak", 32'(io_wr), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
